// File: rtl/piccolo_core_hs_if.sv
// Piccolo core handshake bundle: request side (key, block, options) and result side.
interface piccolo_core_hs_if;
  logic         in_valid;
  logic         in_ready;
  logic         version;
  logic         mode;
  logic [127:0] key;
  logic [63:0]  data_in;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  data_out;
  logic         busy;

  modport master (
    output in_valid, version, mode, key, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, version, mode, key, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/piccolo_core_hs.sv
// Round-iterative Piccolo-80/128 core, one round per clock, valid/ready on both sides.
// Decryption support is built only when PICCOLO_DEC_EN is defined.
module piccolo_core_hs #(
  parameter int ROUNDS_80  = 25,
  parameter int ROUNDS_128 = 31
) (
  input  logic clk,
  input  logic reset,
  piccolo_core_hs_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [63:0] SBOX     = 64'hd5c6_f7a1_9083_2b4e;
  localparam logic [4:0]  LAST_80  = 5'(ROUNDS_80 - 1);
  localparam logic [4:0]  LAST_128 = 5'(ROUNDS_128 - 1);

  state_t state, state_nx;
  logic         ver;
  logic         dec;
  logic [127:0] kr;
  logic [63:0]  st;
  logic [63:0]  dout;
  logic [4:0]   cnt;
  logic [4:0]   last;
  logic [4:0]   ri;
  logic [4:0]   c;
  logic [31:0]  rk;
  logic [15:0]  kx, w0, w1, w2, w3;
  logic [15:0]  wi_a, wi_b, wo_a, wo_b;
  logic [63:0]  mix;

  function automatic logic [3:0] sb(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] g2(input logic [3:0] x);
    return {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
  endfunction

  function automatic logic [3:0] g3(input logic [3:0] x);
    return g2(x) ^ x;
  endfunction

  function automatic logic [15:0] ff(input logic [15:0] x);
    logic [3:0] a0, a1, a2, a3;
    a0 = sb(x[15:12]);
    a1 = sb(x[11:8]);
    a2 = sb(x[7:4]);
    a3 = sb(x[3:0]);
    return {sb(g2(a0) ^ g3(a1) ^ a2 ^ a3),
            sb(a0 ^ g2(a1) ^ g3(a2) ^ a3),
            sb(a0 ^ a1 ^ g2(a2) ^ g3(a3)),
            sb(g3(a0) ^ a1 ^ a2 ^ g2(a3))};
  endfunction

  function automatic logic [63:0] rp(input logic [63:0] x);
    return {x[47:40], x[7:0], x[31:24], x[55:48],
            x[15:8], x[39:32], x[63:56], x[23:16]};
  endfunction

  function automatic logic [127:0] kperm(input logic [127:0] k);
    return {k[95:80], k[111:96], k[31:16], k[15:0],
            k[127:112], k[79:64], k[63:48], k[47:32]};
  endfunction

  // 128-bit schedule: word (j+2)%8 of the key after (j+2)/8 permutations
  function automatic logic [15:0] rk128(input logic [127:0] k,
                                        input logic [5:0] j);
    logic [5:0]   t;
    logic [127:0] kk;
    t  = j + 6'd2;
    kk = k;
    for (int p = 0; p < 7; p++)
      if (3'(p) < t[5:3]) kk = kperm(kk);
    kk = kk << {t[2:0], 4'b0000};
    return kk[127:112];
  endfunction

`ifdef PICCOLO_DEC_EN
  always_ff @(posedge clk) begin
    if (reset) dec <= 1'b0;
    else if (state == IDLE && bus.in_valid) dec <= bus.mode;
  end
`else
  logic unused_mode;
  assign dec         = 1'b0;
  assign unused_mode = bus.mode;
`endif

  assign last = ver ? LAST_128 : LAST_80;
  assign ri   = dec ? last - cnt : cnt;
  assign c    = ri + 5'd1;

  assign kx = ver ? kr[15:0] : kr[79:64];
  assign w0 = {kr[127:120], kr[103:96]};
  assign w1 = {kr[111:104], kr[119:112]};
  assign w2 = {kr[63:56], kx[7:0]};
  assign w3 = {kx[15:8], kr[55:48]};
  assign wi_a = dec ? w2 : w0;
  assign wi_b = dec ? w3 : w1;
  assign wo_a = dec ? w0 : w2;
  assign wo_b = dec ? w1 : w3;

  always_comb begin
    rk = '0;
    if (ver) begin
      rk = {rk128(kr, {ri, 1'b0}), rk128(kr, {ri, 1'b1})};
    end else begin
      unique case (ri % 5'd5)
        5'd0, 5'd2: rk = kr[95:64];
        5'd1, 5'd4: rk = kr[127:96];
        default:    rk = {kr[63:48], kr[63:48]};
      endcase
    end
    rk = rk ^ {c, 5'd0, c, 2'd0, c, 5'd0, c}
            ^ (ver ? 32'h6547a98b : 32'h0f1e2d3c);
    // reverse-order rounds alternate which half feeds which branch
    if (dec && cnt[0]) rk = {rk[15:0], rk[31:16]};
  end

  assign mix = {st[63:48], st[47:32] ^ ff(st[63:48]) ^ rk[31:16],
                st[31:16], st[15:0] ^ ff(st[31:16]) ^ rk[15:0]};

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = LOAD;
      end
      state == LOAD: begin
        bus.busy = 1'b1;
        state_nx = RUN;
      end
      state == RUN: begin
        bus.busy = 1'b1;
        if (cnt == last) state_nx = DONE;
      end
      default: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ver   <= 1'b0;
      kr    <= '0;
      st    <= '0;
      cnt   <= '0;
      dout  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (bus.in_valid) begin
          ver <= bus.version;
          kr  <= bus.version ? bus.key : {bus.key[127:48], 48'd0};
          st  <= bus.data_in;
          cnt <= '0;
        end
        LOAD: st <= st ^ {wi_a, 16'h0, wi_b, 16'h0};
        RUN: begin
          if (cnt == last) begin
            dout <= mix ^ {wo_a, 16'h0, wo_b, 16'h0};
            cnt  <= '0;
          end else begin
            st  <= rp(mix);
            cnt <= cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_out = dout;
endmodule

// File: tb/tb_piccolo_core_hs.sv
// Directed bench for piccolo_core_hs: vector table, round trip, backpressure,
// input churn and mid-run reset, checked against a behavioural Piccolo model.
module tb_piccolo_core_hs;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  piccolo_core_hs_if bus ();
  piccolo_core_hs #(.ROUNDS_80(25), .ROUNDS_128(31)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

`ifdef PICCOLO_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  localparam logic [127:0] K80  = 128'h00112233445566778899_000000000000;
  localparam logic [127:0] K80G = 128'h00112233445566778899_deadbeefcafe;
  localparam logic [127:0] K128 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [63:0]  PT   = 64'h0123456789abcdef;
  localparam logic [63:0]  CT80 = 64'h8d2bff9935f84056;

  int checks = 0;
  int errors = 0;

  int sbx[16] = '{14, 4, 11, 2, 3, 8, 0, 9, 1, 10, 7, 15, 6, 12, 5, 13};
  int mtx[4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
  int rpi[8] = '{2, 7, 4, 1, 6, 3, 0, 5};
  int kpi[8] = '{2, 1, 6, 7, 0, 3, 4, 5};

  typedef struct {
    logic         ver;
    logic         mode;
    logic [127:0] key;
    logic [63:0]  din;
    logic [63:0]  exp;
    int           lat;
  } vec_t;

  vec_t vt[6];

  function automatic logic [3:0] gmul(input logic [3:0] a_in, input logic [3:0] b_in);
    logic [3:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[0]) p = p ^ a;
      a = a[3] ? ({a[2:0], 1'b0} ^ 4'h3) : {a[2:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [15:0] mf(input logic [15:0] x);
    logic [3:0]  s[4];
    logic [3:0]  y;
    logic [15:0] o;
    for (int r = 0; r < 4; r++) s[r] = 4'(sbx[x[15-4*r -: 4]]);
    o = '0;
    for (int r = 0; r < 4; r++) begin
      y = '0;
      for (int cc = 0; cc < 4; cc++) y = y ^ gmul(4'(mtx[r][cc]), s[cc]);
      o[15-4*r -: 4] = 4'(sbx[y]);
    end
    return o;
  endfunction

  function automatic logic [63:0] model(input logic v, input logic d,
                                        input logic [127:0] k, input logic [63:0] din);
    logic [15:0] kw[8];
    logic [15:0] tk[8];
    logic [15:0] rk[62];
    logic [15:0] rkd[62];
    logic [15:0] wk[4];
    logic [15:0] t0, t1;
    logic [15:0] x[4];
    logic [7:0]  bt[8];
    logic [7:0]  nb[8];
    logic [31:0] cn;
    logic [4:0]  c;
    int r;
    r = v ? 31 : 25;
    for (int m = 0; m < 8; m++) kw[m] = k[127-16*m -: 16];
    wk[0] = {kw[0][15:8], kw[1][7:0]};
    wk[1] = {kw[1][15:8], kw[0][7:0]};
    wk[2] = {kw[4][15:8], kw[v ? 7 : 3][7:0]};
    wk[3] = {kw[v ? 7 : 3][15:8], kw[4][7:0]};
    for (int i = 0; i < 62; i++) rk[i] = '0;
    for (int i = 0; i < r; i++) begin
      c  = 5'(i + 1);
      cn = {c, 5'b0, c, 2'b0, c, 5'b0, c} ^ (v ? 32'h6547a98b : 32'h0f1e2d3c);
      if (!v) begin
        case (i % 5)
          0, 2: begin rk[2*i] = kw[2]; rk[2*i+1] = kw[3]; end
          1, 4: begin rk[2*i] = kw[0]; rk[2*i+1] = kw[1]; end
          default: begin rk[2*i] = kw[4]; rk[2*i+1] = kw[4]; end
        endcase
      end else begin
        for (int h = 0; h < 2; h++) begin
          if ((2*i + h + 2) % 8 == 0) begin
            tk = kw;
            for (int m = 0; m < 8; m++) kw[m] = tk[kpi[m]];
          end
          rk[2*i+h] = kw[(2*i + h + 2) % 8];
        end
      end
      rk[2*i]   = rk[2*i] ^ cn[31:16];
      rk[2*i+1] = rk[2*i+1] ^ cn[15:0];
    end
    if (d) begin
      t0 = wk[0]; t1 = wk[1];
      wk[0] = wk[2]; wk[1] = wk[3]; wk[2] = t0; wk[3] = t1;
      for (int i = 0; i < 62; i++) rkd[i] = '0;
      for (int i = 0; i < r; i++) begin
        if (i % 2 == 0) begin
          rkd[2*i] = rk[2*r-2*i-2]; rkd[2*i+1] = rk[2*r-2*i-1];
        end else begin
          rkd[2*i] = rk[2*r-2*i-1]; rkd[2*i+1] = rk[2*r-2*i-2];
        end
      end
      rk = rkd;
    end
    for (int m = 0; m < 4; m++) x[m] = din[63-16*m -: 16];
    x[0] = x[0] ^ wk[0];
    x[2] = x[2] ^ wk[1];
    for (int i = 0; i < r; i++) begin
      x[1] = x[1] ^ mf(x[0]) ^ rk[2*i];
      x[3] = x[3] ^ mf(x[2]) ^ rk[2*i+1];
      if (i < r - 1) begin
        for (int m = 0; m < 4; m++) begin
          bt[2*m] = x[m][15:8]; bt[2*m+1] = x[m][7:0];
        end
        for (int m = 0; m < 8; m++) nb[m] = bt[rpi[m]];
        for (int m = 0; m < 4; m++) x[m] = {nb[2*m], nb[2*m+1]};
      end
    end
    x[0] = x[0] ^ wk[2];
    x[2] = x[2] ^ wk[3];
    return {x[0], x[1], x[2], x[3]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_txn(input logic v, input logic m,
                           input logic [127:0] k, input logic [63:0] d);
    int w;
    bus.version = v; bus.mode = m; bus.key = k; bus.data_in = d;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output logic [63:0] res, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    res = bus.data_out;
  endtask

  task automatic run_txn(input logic v, input logic m, input logic [127:0] k,
                         input logic [63:0] d, output logic [63:0] res, output int lat);
    start_txn(v, m, k, d);
    wait_done(res, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] res, res_e, cap, exp;
    int lat;
    bit ok;

    vt[0] = '{1'b0, 1'b0, K80, PT, CT80, 26};
    vt[1] = '{1'b0, 1'b0, K80G, PT, CT80, 26};
    vt[2] = '{1'b1, 1'b0, K128, PT, model(1'b1, 1'b0, K128, PT), 32};
    vt[3] = '{1'b0, 1'b1, K80, CT80,
              DEC_EN ? PT : model(1'b0, 1'b0, K80, CT80), 26};
    vt[4] = '{1'b1, 1'b0, {128{1'b1}}, {64{1'b1}},
              model(1'b1, 1'b0, {128{1'b1}}, {64{1'b1}}), 32};
    vt[5] = '{1'b0, 1'b0, 128'h0, 64'h0, model(1'b0, 1'b0, 128'h0, 64'h0), 26};

    chk("model_kat80", model(1'b0, 1'b0, K80, PT), CT80);

    bus.in_valid = 1'b0; bus.version = 1'b0; bus.mode = 1'b0;
    bus.key = '0; bus.data_in = '0; bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_data_out", bus.data_out, 64'd0);

    for (int n = 0; n < 6; n++) begin
      run_txn(vt[n].ver, vt[n].mode, vt[n].key, vt[n].din, res, lat);
      chk($sformatf("vec%0d_data", n), res, vt[n].exp);
      chk($sformatf("vec%0d_lat", n), 64'(lat), 64'(vt[n].lat));
    end

    // 128-bit round trip
    run_txn(1'b1, 1'b0, K128, PT, res_e, lat);
    chk("rt_enc_data", res_e, model(1'b1, 1'b0, K128, PT));
    chk("rt_enc_lat", 64'(lat), 64'd32);
    run_txn(1'b1, 1'b1, K128, res_e, res, lat);
    exp = DEC_EN ? PT : model(1'b1, 1'b0, K128, res_e);
    chk("rt_dec_data", res, exp);
    chk("rt_dec_lat", 64'(lat), 64'd32);

    // backpressure with a held follow-on request
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    start_txn(1'b0, 1'b0, K80, PT);
    bus.in_valid = 1'b1;
    wait_done(cap, lat);
    chk("bp_data", cap, CT80);
    chk("bp_lat", 64'(lat), 64'd26);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!bus.out_valid || bus.data_out !== cap || bus.in_ready || bus.busy) ok = 1'b0;
    end
    chk("bp_hold", 64'(ok), 64'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_accept", {62'd0, bus.busy, bus.in_ready}, 64'd2);
    bus.in_valid = 1'b0;
    wait_done(res, lat);
    chk("bp_next_data", res, CT80);
    chk("bp_next_lat", 64'(lat), 64'd26);

    // inputs churn while running
    @(posedge clk); #1;
    start_txn(1'b0, 1'b0, K80, PT);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      bus.key = {$urandom, $urandom, $urandom, $urandom};
      bus.data_in = {$urandom, $urandom};
      bus.version = 1'($urandom_range(0, 1));
      bus.mode = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    chk("churn_data", bus.data_out, CT80);
    chk("churn_lat", 64'(lat), 64'd26);

    // reset at round 7
    @(posedge clk); #1;
    start_txn(1'b1, 1'b0, K128, PT);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mrst_data_out", bus.data_out, 64'd0);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) ok = 1'b0;
    end
    chk("mrst_no_valid", 64'(ok), 64'd1);
    run_txn(1'b0, 1'b0, K80, PT, res, lat);
    chk("mrst_next_data", res, CT80);
    chk("mrst_next_lat", 64'(lat), 64'd26);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
